// File: rtl/updown_counter_disp.sv
// Parametrised up/down counter (load, wrap/saturate, terminal count) with a
// multiplexed active-low hex display driver. Define UDC_DIR_GLYPH_EN for a direction glyph slot.
module updown_counter_disp #(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned MAX_VAL  = 2**WIDTH - 1,
  parameter int unsigned SCAN_DIV = 50000,
  localparam int unsigned DIGITS  = WIDTH / 4,
`ifdef UDC_DIR_GLYPH_EN
  localparam int unsigned NSLOT   = DIGITS + 1
`else
  localparam int unsigned NSLOT   = DIGITS
`endif
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             sat,
  output logic [WIDTH-1:0] q,
  output logic             tc,
  output logic             at_max,
  output logic             at_min,
  output logic [6:0]       seg,
  output logic             dp,
  output logic [NSLOT-1:0] an
);

  localparam int unsigned PW = $clog2(SCAN_DIV);
  localparam int unsigned SW = (NSLOT > 1) ? $clog2(NSLOT) : 1;

  localparam logic [WIDTH-1:0] MaxQ   = WIDTH'(MAX_VAL);
  localparam logic [WIDTH:0]   MaxExt = (WIDTH + 1)'(MAX_VAL);

  logic [WIDTH-1:0] q_q, q_d;
  logic             tc_q, tc_d;
  logic [PW-1:0]    presc_q, presc_d;
  logic [SW-1:0]    slot_q, slot_d;
  logic [6:0]       seg_q, seg_d;
  logic             dp_q, dp_d;
  logic [NSLOT-1:0] an_q, an_d;

`ifdef UDC_DIR_GLYPH_EN
  logic             dir_q, dir_d;
`endif

  // One extra bit so MAX_VAL = 2**WIDTH-1 never loses the carry.
  logic [WIDTH:0] q_ext, inc_sum, dec_sum, load_ext;
  logic [3:0]     digit;

  assign q_ext    = {1'b0, q_q};
  assign inc_sum  = q_ext + (WIDTH + 1)'(1);
  assign dec_sum  = q_ext - (WIDTH + 1)'(1);
  assign load_ext = {1'b0, load_val};

  assign at_max = (q_q == MaxQ);
  assign at_min = (q_q == '0);

  function automatic logic [6:0] hex_glyph(input logic [3:0] d);
    logic [6:0] g;
    unique case (d)
      4'h0: g = 7'b0000001;
      4'h1: g = 7'b1001111;
      4'h2: g = 7'b0010010;
      4'h3: g = 7'b0000110;
      4'h4: g = 7'b1001100;
      4'h5: g = 7'b0100100;
      4'h6: g = 7'b0100000;
      4'h7: g = 7'b0001111;
      4'h8: g = 7'b0000000;
      4'h9: g = 7'b0000100;
      4'hA: g = 7'b0001000;
      4'hB: g = 7'b1100000;
      4'hC: g = 7'b0110001;
      4'hD: g = 7'b1000010;
      4'hE: g = 7'b0110000;
      default: g = 7'b0111000;
    endcase
    return g;
  endfunction

  // Counter next state; load beats enable, and a load always clears tc.
  always_comb begin
    q_d  = q_q;
    tc_d = 1'b0;
    if (load) begin
      q_d = (load_ext > MaxExt) ? MaxQ : load_val;
    end else if (en) begin
      if (up) begin
        tc_d = at_max;
        if (inc_sum > MaxExt) begin
          q_d = sat ? MaxQ : '0;
        end else begin
          q_d = inc_sum[WIDTH-1:0];
        end
      end else begin
        tc_d = at_min;
        if (at_min) begin
          q_d = sat ? '0 : MaxQ;
        end else begin
          q_d = dec_sum[WIDTH-1:0];
        end
      end
    end
  end

`ifdef UDC_DIR_GLYPH_EN
  always_comb begin
    dir_d = dir_q;
    if (en && !load) begin
      dir_d = up;
    end
  end
`endif

  // Scan timing: prescaler rolls over every SCAN_DIV cycles and advances the slot.
  always_comb begin
    presc_d = presc_q + PW'(1);
    slot_d  = slot_q;
    if (presc_q == PW'(SCAN_DIV - 1)) begin
      presc_d = '0;
      slot_d  = (slot_q == SW'(NSLOT - 1)) ? '0 : slot_q + SW'(1);
    end
  end

  // Display drive is built from the current slot and q, so it lags by one cycle.
  always_comb begin
    digit = 4'(q_q >> {slot_q, 2'b00});
    seg_d = hex_glyph(digit);
    dp_d  = ~((slot_q == '0) & (at_max | at_min));
    an_d  = ~(NSLOT'(1) << slot_q);
`ifdef UDC_DIR_GLYPH_EN
    if (slot_q == SW'(DIGITS)) begin
      seg_d = dir_q ? 7'b1000001 : 7'b1000010;
      dp_d  = 1'b1;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      q_q     <= '0;
      tc_q    <= 1'b0;
      presc_q <= '0;
      slot_q  <= '0;
      seg_q   <= '1;
      dp_q    <= 1'b1;
      an_q    <= '1;
    end else begin
      q_q     <= q_d;
      tc_q    <= tc_d;
      presc_q <= presc_d;
      slot_q  <= slot_d;
      seg_q   <= seg_d;
      dp_q    <= dp_d;
      an_q    <= an_d;
    end
  end

`ifdef UDC_DIR_GLYPH_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      dir_q <= 1'b1;
    end else begin
      dir_q <= dir_d;
    end
  end
`endif

  assign q   = q_q;
  assign tc  = tc_q;
  assign seg = seg_q;
  assign dp  = dp_q;
  assign an  = an_q;

endmodule
